// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, redirect flushes, memory back-pressure.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic [4:0]       id_r1_addr,
  input  logic             id_r1_rd,
  input  logic [4:0]       id_r2_addr,
  input  logic             id_r2_rd,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_wr_en,
  input  logic             mem_busy,
  input  logic             if_busy,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [2:0]       stall,
  output logic             clear,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             fwd_ex_enable,
`ifdef HAZARD_PERF_CNT_EN
  output logic             fwd_mem_enable,
  output logic [CNT_W-1:0] perf_lu_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_mem_cnt
`else
  output logic             fwd_mem_enable
`endif
);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] rpc_q, rpc_d;
  logic        rv_q, rv_d;
  logic [2:0]  stall_c;
  logic        clear_c;
  logic        lu;
  logic        lu_stall;
  logic        flush_clr;
  logic        accept;
  logic [31:0] accept_pc;

  assign fwd_ex_enable  = ex_wr_en & (ex_rd_addr != 5'd0) & ~ex_is_load;
  assign fwd_mem_enable = mem_wr_en & (mem_rd_addr != 5'd0);

  assign lu = ex_is_load & ex_wr_en & (ex_rd_addr != 5'd0) &
              ((id_r1_rd & (id_r1_addr == ex_rd_addr)) |
               (id_r2_rd & (id_r2_addr == ex_rd_addr)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    rpc_d     = rpc_q;
    rv_d      = 1'b0;
    stall_c   = 3'b000;
    clear_c   = 1'b0;
    lu_stall  = 1'b0;
    flush_clr = 1'b0;
    accept    = 1'b0;
    accept_pc = br_target;

    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          stall_c = 3'b111;
          state_d = StMemWait;
          if (br_taken) begin
            pend_d    = 1'b1;
            pend_pc_d = br_target;
          end
        end else if (br_taken) begin
          accept = 1'b1;
        end else if (lu) begin
          stall_c  = 3'b011;
          clear_c  = 1'b1;
          lu_stall = 1'b1;
        end else if (if_busy) begin
          stall_c = 3'b001;
          clear_c = 1'b1;
        end
      end
      StFlush: begin
        if (mem_busy) begin
          // Counter freezes; the remaining flush resumes after the wait.
          stall_c = 3'b111;
          state_d = StMemWait;
        end else begin
          clear_c   = 1'b1;
          flush_clr = 1'b1;
          cnt_d     = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = StRun;
        end
      end
      StMemWait: begin
        if (mem_busy) begin
          stall_c = 3'b111;
        end else if (pend_q) begin
          accept    = 1'b1;
          accept_pc = pend_pc_q;
          pend_d    = 1'b0;
        end else if (cnt_q != 3'd0) begin
          state_d = StFlush;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (accept) begin
      rpc_d     = accept_pc;
      rv_d      = 1'b1;
      clear_c   = 1'b1;
      flush_clr = 1'b1;
      cnt_d     = FlushInit;
      state_d   = (FLUSH_CYCLES == 1) ? StRun : StFlush;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StRun;
      cnt_q     <= 3'd0;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
      rpc_q     <= 32'd0;
      rv_q      <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      rpc_q     <= rpc_d;
      rv_q      <= rv_d;
    end
  end

  always_comb begin
    stall = stall_c;
    clear = clear_c;
    if (!rst_n_in) begin
      stall = 3'b000;
      clear = 1'b1;
    end else if (!rdy_in) begin
      stall = 3'b111;
      clear = 1'b0;
    end
  end

  // A strobe caught by rdy_in low is held and delivered once ready returns.
  assign redirect_valid = rv_q & rdy_in;
  assign redirect_pc    = rpc_q;

`ifdef HAZARD_PERF_CNT_EN
  logic mem_cyc;
  assign mem_cyc = (state_q == StMemWait);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_lu_cnt    <= '0;
      perf_flush_cnt <= '0;
      perf_mem_cnt   <= '0;
    end else if (rdy_in) begin
      if (lu_stall && (perf_lu_cnt != '1))     perf_lu_cnt    <= perf_lu_cnt + 1'b1;
      if (flush_clr && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (mem_cyc && (perf_mem_cnt != '1))     perf_mem_cnt   <= perf_mem_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with FLUSH_CYCLES = 2.
module tb_hazard_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic [4:0]  id_r1_addr, id_r2_addr, ex_rd_addr, mem_rd_addr;
  logic        id_r1_rd, id_r2_rd, ex_wr_en, ex_is_load, mem_wr_en;
  logic        mem_busy, if_busy, br_taken;
  logic [31:0] br_target;
  logic [2:0]  stall;
  logic        clear, redirect_valid, fwd_ex_enable, fwd_mem_enable;
  logic [31:0] redirect_pc;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_mem_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .id_r1_addr     (id_r1_addr),
    .id_r1_rd       (id_r1_rd),
    .id_r2_addr     (id_r2_addr),
    .id_r2_rd       (id_r2_rd),
    .ex_rd_addr     (ex_rd_addr),
    .ex_wr_en       (ex_wr_en),
    .ex_is_load     (ex_is_load),
    .mem_rd_addr    (mem_rd_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_busy       (mem_busy),
    .if_busy        (if_busy),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .stall          (stall),
    .clear          (clear),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fwd_ex_enable  (fwd_ex_enable),
`ifdef HAZARD_PERF_CNT_EN
    .fwd_mem_enable (fwd_mem_enable),
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_mem_cnt   (perf_mem_cnt)
`else
    .fwd_mem_enable (fwd_mem_enable)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Sample mid-cycle, away from the active edge.
  task automatic smp();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rdy_in = 1'b1;
    id_r1_addr = 5'd0; id_r1_rd = 1'b0; id_r2_addr = 5'd0; id_r2_rd = 1'b0;
    ex_rd_addr = 5'd0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_rd_addr = 5'd0; mem_wr_en = 1'b0;
    mem_busy = 1'b0; if_busy = 1'b0; br_taken = 1'b0; br_target = 32'd0;
  endtask

  task automatic chk_sc(input string tag, input logic [2:0] s, input logic c);
    check_eq({tag, ".stall"}, {29'd0, stall}, {29'd0, s});
    check_eq({tag, ".clear"}, {31'd0, clear}, {31'd0, c});
  endtask

  initial begin
    idle();
    rst_n_in = 1'b0;

    // Reset
    smp();
    chk_sc("rst", 3'b000, 1'b1);
    check_eq("rst.rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst.rpc", redirect_pc, 32'd0);
    cyc(); cyc(); cyc();
    rst_n_in = 1'b1;
    smp();
    chk_sc("rel", 3'b000, 1'b0);
    check_eq("rel.rpc", redirect_pc, 32'd0);

    // Load-use on r2
    cyc();
    ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd_addr = 5'd5; id_r2_rd = 1'b1; id_r2_addr = 5'd5;
    smp();
    chk_sc("lu", 3'b011, 1'b1);
    cyc();
    idle(); mem_wr_en = 1'b1; mem_rd_addr = 5'd5;
    smp();
    chk_sc("lu.after", 3'b000, 1'b0);
    check_eq("lu.fwdmem", {31'd0, fwd_mem_enable}, 32'd1);
    cyc();
    idle(); ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd_addr = 5'd0; id_r2_rd = 1'b1;
    smp();
    chk_sc("lu.x0", 3'b000, 1'b0);
    cyc();
    idle(); ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd_addr = 5'd3; id_r1_addr = 5'd3;
    smp();
    chk_sc("lu.nord", 3'b000, 1'b0);

    // Forwarding
    cyc();
    idle(); ex_wr_en = 1'b1; ex_rd_addr = 5'd3;
    smp();
    check_eq("fwd.ex", {31'd0, fwd_ex_enable}, 32'd1);
    ex_is_load = 1'b1; #1;
    check_eq("fwd.exld", {31'd0, fwd_ex_enable}, 32'd0);
    mem_wr_en = 1'b1; mem_rd_addr = 5'd0; #1;
    check_eq("fwd.mem0", {31'd0, fwd_mem_enable}, 32'd0);

    // if_busy
    cyc();
    idle(); if_busy = 1'b1;
    smp();
    chk_sc("ifb", 3'b001, 1'b1);

    // Branch with simultaneous load-use: branch wins
    cyc();
    idle(); br_taken = 1'b1; br_target = 32'h0000_1040;
    ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd_addr = 5'd7; id_r1_rd = 1'b1; id_r1_addr = 5'd7;
    smp();
    chk_sc("br.a", 3'b000, 1'b1);
    check_eq("br.a.rv", {31'd0, redirect_valid}, 32'd0);
    cyc();
    idle(); br_taken = 1'b1; br_target = 32'hDEAD_BEEF;
    smp();
    chk_sc("br.b", 3'b000, 1'b1);
    check_eq("br.b.rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("br.b.rpc", redirect_pc, 32'h0000_1040);
    cyc();
    idle();
    smp();
    chk_sc("br.c", 3'b000, 1'b0);
    check_eq("br.c.rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("br.c.rpc", redirect_pc, 32'h0000_1040);

    // Branch arriving with the mem_busy rise
    cyc();
    idle(); mem_busy = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0200;
    smp();
    chk_sc("mw.0", 3'b111, 1'b0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      idle(); mem_busy = 1'b1;
      smp();
      chk_sc($sformatf("mw.%0d", i), 3'b111, 1'b0);
      check_eq($sformatf("mw.%0d.rv", i), {31'd0, redirect_valid}, 32'd0);
    end
    cyc();
    idle();
    smp();
    chk_sc("mw.4", 3'b000, 1'b1);
    check_eq("mw.4.rv", {31'd0, redirect_valid}, 32'd0);
    cyc();
    smp();
    chk_sc("mw.5", 3'b000, 1'b1);
    check_eq("mw.5.rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("mw.5.rpc", redirect_pc, 32'h0000_0200);
    cyc();
    smp();
    chk_sc("mw.6", 3'b000, 1'b0);
    check_eq("mw.6.rv", {31'd0, redirect_valid}, 32'd0);

    // rdy_in low freezes a pending strobe
    cyc();
    idle(); br_taken = 1'b1; br_target = 32'h0000_3000;
    smp();
    chk_sc("rdy.a", 3'b000, 1'b1);
    cyc();
    idle(); rdy_in = 1'b0;
    smp();
    chk_sc("rdy.b", 3'b111, 1'b0);
    check_eq("rdy.b.rv", {31'd0, redirect_valid}, 32'd0);
    cyc();
    idle();
    smp();
    chk_sc("rdy.c", 3'b000, 1'b1);
    check_eq("rdy.c.rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("rdy.c.rpc", redirect_pc, 32'h0000_3000);
    cyc();
    smp();
    chk_sc("rdy.d", 3'b000, 1'b0);

    // Asynchronous reset in FLUSH
    cyc();
    idle(); br_taken = 1'b1; br_target = 32'h0000_4000;
    cyc();
    idle();
    #2;
    check_eq("ar.pre.rv", {31'd0, redirect_valid}, 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk_sc("ar", 3'b000, 1'b1);
    check_eq("ar.rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("ar.rpc", redirect_pc, 32'd0);
    cyc();
    rst_n_in = 1'b1;
    smp();
    chk_sc("ar.rel", 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core.
- Drives the `stall[2:0]` and `clear` inputs of the ID/EX pipeline register and the forwarding-enable pair.
- Resolves load-use hazards, taken-branch flushes and memory back-pressure; holds a pending redirect while memory is busy.
- Sits beside the decode stage; takes hazard inputs from ID, EX, MEM and the memory controller.

Parameters:
- FLUSH_CYCLES, 2: cycles `clear` stays asserted after a redirect (range 1..7).
- CNT_W, 32: width of the performance counters.

Ports:
- clk_in  input  1  core clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global ready; when low, state and counters hold and all stall bits are 1
- id_r1_addr  input  5  ID source register 1
- id_r1_rd  input  1  ID actually reads r1
- id_r2_addr  input  5  ID source register 2
- id_r2_rd  input  1  ID actually reads r2
- ex_rd_addr  input  5  EX destination register
- ex_wr_en  input  1  EX writes rd
- ex_is_load  input  1  EX instruction is a load
- mem_rd_addr  input  5  MEM destination register
- mem_wr_en  input  1  MEM writes rd
- mem_busy  input  1  MEM waiting on the memory controller
- if_busy  input  1  IF waiting on instruction fetch
- br_taken  input  1  EX resolved a taken branch or jump (one-cycle pulse)
- br_target  input  32  redirect target
- stall  output  3  bit0 hold PC/IF; bit1 hold IF/ID; bit2 hold ID/EX and EX/MEM
- clear  output  1  bubble into IF/ID and ID/EX
- redirect_valid  output  1  one-cycle PC redirect strobe
- redirect_pc  output  32  redirect address, registered
- fwd_ex_enable  output  1  EX result is forwardable
- fwd_mem_enable  output  1  MEM result is forwardable

Behaviour:
- Forwarding (combinational):
  - `fwd_ex_enable = ex_wr_en & (ex_rd_addr != 0) & ~ex_is_load`.
  - `fwd_mem_enable = mem_wr_en & (mem_rd_addr != 0)`.
- Load-use hazard (combinational): `lu = ex_is_load & ex_wr_en & (ex_rd_addr != 0) & ((id_r1_rd & id_r1_addr == ex_rd_addr) | (id_r2_rd & id_r2_addr == ex_rd_addr))`.
- FSM states: RUN, FLUSH, MEM_WAIT. Reset state is RUN.
  - Reset (asynchronous, low) forces: `redirect_pc = 0`, `redirect_valid = 0`, flush counter `= 0`, pend flag `= 0`, counters `= 0`.
  - During reset: `stall = 3'b000` and `clear = 1`.
- RUN, evaluated in priority order:
  1. `mem_busy`: `stall = 3'b111`, `clear = 0`, go to MEM_WAIT. If `br_taken`, latch `br_target` and set pend.
  2. `br_taken`: load `redirect_pc <= br_target`; assert `redirect_valid` next cycle; `clear = 1`; load flush counter with `FLUSH_CYCLES-1`; go to FLUSH (stay in RUN if `FLUSH_CYCLES == 1`).
  3. `lu`: `stall = 3'b011` (PC and IF/ID hold; ID/EX receives a bubble through `clear = 1`). Lasts exactly one cycle, because the load moves to MEM and `lu` drops.
  4. `if_busy`: `stall = 3'b001`, `clear = 1` (bubble into IF/ID only).
  5. Otherwise: `stall = 0`, `clear = 0`.
- FLUSH:
  - `clear = 1`, `stall = 0`; counter decrements each cycle; return to RUN when it reaches 0.
  - `mem_busy` during FLUSH: go to MEM_WAIT, `stall = 3'b111`, counter frozen, resumes afterwards.
  - A new `br_taken` in FLUSH is ignored; the younger instruction is already squashed.
- MEM_WAIT:
  - `stall = 3'b111`, `clear = 0`, `br_taken` ignored.
  - On the first cycle `mem_busy = 0`:
    - if pend: perform the redirect as in RUN step 2 and clear pend;
    - else if the frozen flush counter is nonzero: go to FLUSH;
    - else: go to RUN.
- `redirect_valid` is high for exactly one cycle per accepted redirect, one cycle after acceptance.
- Simultaneous `lu` and `br_taken`: the branch wins; no stall cycle occurs.
- `rdy_in = 0`: all state frozen, `stall = 3'b111`, `clear = 0`, `redirect_valid` held low.

Optional Feature:
- Macro `HAZARD_PERF_CNT_EN`.
- When defined, adds outputs `perf_lu_cnt`, `perf_flush_cnt` and `perf_mem_cnt`, each CNT_W wide.
  - They count load-use stall cycles, `clear`-asserted flush cycles and MEM_WAIT cycles.
  - Counters saturate at all-ones and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release: `rst_n_in` low for 3 cycles, then high with idle inputs → `stall = 0`, `clear = 0`, `redirect_pc = 0`, state RUN.
- Load-use: `ex_is_load = 1`, `ex_wr_en = 1`, `ex_rd_addr = 5`, `id_r2_rd = 1`, `id_r2_addr = 5` → exactly one cycle of `stall = 3'b011` with `clear = 1`, then `stall = 0`. Repeat with `ex_rd_addr = 0` → no stall.
- Branch: `br_taken` pulse with `br_target = 0x0000_1040` and `FLUSH_CYCLES = 2` → `clear` high for 2 cycles, `redirect_valid` high for 1 cycle, `redirect_pc = 0x1040`.
- Branch during memory wait: `mem_busy` high for 4 cycles, `br_taken` with target 0x200 arriving in the same cycle as the `mem_busy` rise → `stall = 3'b111` for 4 cycles, then redirect to 0x200 and a 2-cycle flush.
- Forwarding: `ex_wr_en = 1`, `ex_rd_addr = 3`, `ex_is_load = 0` → `fwd_ex_enable = 1`. Set `ex_is_load = 1` → `fwd_ex_enable = 0`. `mem_rd_addr = 0` → `fwd_mem_enable = 0`.
- Mid-operation reset: assert `rst_n_in` low during FLUSH → `clear = 1` and `redirect_valid = 0` immediately, with no clock edge required.
